// File: rtl/param_logic_dut_if.sv
// Handshake bundle for param_logic_dut: two operand inputs, op select,
// one result output and the per-input occupancy counts.
interface param_logic_dut_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] A_data;
  logic             A_enable;
  logic             A_ready;
  logic [WIDTH-1:0] B_data;
  logic             B_enable;
  logic             B_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] Y_data;
  logic             Y_enable;
  logic             Y_ready;
  logic [CW-1:0]    A_count;
  logic [CW-1:0]    B_count;

  // Producer/consumer side
  modport master (
    output A_data, A_enable, B_data, B_enable, op, Y_ready,
    input  A_ready, B_ready, Y_data, Y_enable, A_count, B_count
  );

  // Logic unit side
  modport slave (
    input  A_data, A_enable, B_data, B_enable, op, Y_ready,
    output A_ready, B_ready, Y_data, Y_enable, A_count, B_count
  );
endinterface

// File: rtl/param_logic_dut.sv
// Two-operand bitwise logic unit. Each operand is buffered in its own
// DEPTH-entry FIFO; a join stage pops both heads together, applies the
// selected operation and holds the result in a single output register.
module param_logic_dut #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input logic              clk,
  input logic              reset,
  param_logic_dut_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    OP_XOR  = 2'd0,
    OP_AND  = 2'd1,
    OP_OR   = 2'd2,
    OP_XNOR = 2'd3
  } op_e;

  logic             live;
  logic [WIDTH-1:0] a_mem [DEPTH];
  logic [WIDTH-1:0] b_mem [DEPTH];
  logic [PW-1:0]    a_wr, a_rd, b_wr, b_rd;
  logic [CW-1:0]    a_cnt, b_cnt;
  logic             a_push, b_push, pop, slot_free;
  logic [WIDTH-1:0] y_res;
  logic [WIDTH-1:0] y_data_q;
  logic             y_en_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready depends only on registered state; 'live' keeps it low in reset
  // and raises it on the first edge after release.
  assign bus.A_ready = live & (a_cnt != CW'(DEPTH));
  assign bus.B_ready = live & (b_cnt != CW'(DEPTH));
  assign a_push      = bus.A_enable & bus.A_ready;
  assign b_push      = bus.B_enable & bus.B_ready;
  assign slot_free   = ~y_en_q | bus.Y_ready;
  assign pop         = (a_cnt != '0) & (b_cnt != '0) & slot_free;

  assign bus.A_count  = a_cnt;
  assign bus.B_count  = b_cnt;
  assign bus.Y_data   = y_data_q;
  assign bus.Y_enable = y_en_q;

  // Ready-enable flag: low throughout reset, high from the first edge after
  always_ff @(posedge clk or posedge reset) begin
    if (reset) live <= 1'b0;
    else       live <= 1'b1;
  end

  // FIFO storage writes (contents are don't-care once counts are cleared)
  always_ff @(posedge clk) begin
    if (a_push) a_mem[a_wr] <= bus.A_data;
    if (b_push) b_mem[b_wr] <= bus.B_data;
  end

  // A FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_wr  <= '0;
      a_rd  <= '0;
      a_cnt <= '0;
    end else begin
      if (a_push) a_wr <= ptr_inc(a_wr);
      if (pop)    a_rd <= ptr_inc(a_rd);
      if (a_push && !pop)      a_cnt <= a_cnt + CW'(1);
      else if (!a_push && pop) a_cnt <= a_cnt - CW'(1);
    end
  end

  // B FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_wr  <= '0;
      b_rd  <= '0;
      b_cnt <= '0;
    end else begin
      if (b_push) b_wr <= ptr_inc(b_wr);
      if (pop)    b_rd <= ptr_inc(b_rd);
      if (b_push && !pop)      b_cnt <= b_cnt + CW'(1);
      else if (!b_push && pop) b_cnt <= b_cnt - CW'(1);
    end
  end

  // Selected bitwise operation on the two FIFO heads
  always_comb begin
    y_res = '0;
    case (op_e'(bus.op))
      OP_XOR:  y_res = a_mem[a_rd] ^ b_mem[b_rd];
      OP_AND:  y_res = a_mem[a_rd] & b_mem[b_rd];
      OP_OR:   y_res = a_mem[a_rd] | b_mem[b_rd];
      OP_XNOR: y_res = ~(a_mem[a_rd] ^ b_mem[b_rd]);
      default: y_res = '0;
    endcase
  end

  // Output register: load on join, release on consumer accept, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_data_q <= '0;
      y_en_q   <= 1'b0;
    end else if (pop) begin
      y_data_q <= y_res;
      y_en_q   <= 1'b1;
    end else if (y_en_q && bus.Y_ready) begin
      y_en_q   <= 1'b0;
    end
  end
endmodule

// File: doc/param_logic_dut.md
Name: param_logic_dut

Overview:
- Parametrised two-operand bitwise logic unit with elastic valid/ready (enable/ready) interfaces on both inputs and on the output.
- Each input has its own DEPTH-entry FIFO. A join stage pops both FIFOs together, applies the selected operation, and holds the result in a single output register.
- Generalises the 1-bit single-entry XOR datapath to WIDTH bits, configurable buffering, runtime operation select and occupancy status.
- Sits between two independent producers and one consumer.

Parameters:
- WIDTH, 8, data width of A, B and Y.
- DEPTH, 2, entries per input FIFO. Must be a power of 2 and at least 1.
- CW, $clog2(DEPTH+1), width of the occupancy count outputs. Derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- A_data  input  WIDTH  operand A.
- A_enable  input  1  A_data valid.
- A_ready  output  1  A FIFO can accept.
- B_data  input  WIDTH  operand B.
- B_enable  input  1  B_data valid.
- B_ready  output  1  B FIFO can accept.
- op  input  2  operation select: 0 XOR, 1 AND, 2 OR, 3 XNOR.
- Y_data  output  WIDTH  result.
- Y_enable  output  1  Y_data valid.
- Y_ready  input  1  consumer accepts.
- A_count  output  CW  entries currently held in the A FIFO.
- B_count  output  CW  entries currently held in the B FIFO.

Behaviour:
- Transfer rule: a transfer occurs on a rising edge where enable and ready are both high. The same rule applies on every port pair.
- Reset (asynchronous assert, takes effect immediately):
  - FIFOs empty; A_count = B_count = 0.
  - Y_enable = 0; Y_data = 0.
  - A_ready = B_ready = 0 while reset is high.
  - Both ready outputs go high in the first cycle after release.
  - Reset mid-operation discards all buffered and in-flight data; nothing is replayed.
- Input FIFOs:
  - X_ready = !full. It is driven by registered state only, with no combinational path from Y_ready or op.
  - A full FIFO deasserts ready even in a cycle where it is being popped; the slot reopens in the next cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - Data is FIFO-ordered. A and B are paired strictly by arrival index: the k-th A combines with the k-th B.
- Join and output stage:
  - Output slot is free when Y_enable == 0, or when Y_enable & Y_ready is high in this cycle.
  - fire = (A_count != 0) & (B_count != 0) & slot free.
  - On fire: pop one entry from each FIFO; Y_data <= f(op, A_head, B_head); Y_enable <= 1.
  - op is sampled at the fire edge only. Changing op while a result is held does not alter the held Y_data.
  - On Y_enable & Y_ready without fire: Y_enable <= 0. Y_data keeps its last value (don't-care).
  - While Y_enable & !Y_ready: Y_data and Y_enable hold stable.
- Timing:
  - Latency: inputs accepted at edge t give Y_enable = 1 in the cycle after edge t+1, i.e. 2 cycles minimum.
  - Throughput: one result per cycle with both inputs streaming and Y_ready held high.
- Imbalance: if only one side has data, it accumulates up to DEPTH entries, then its ready drops. No output is produced until the other side supplies a matching entry.
- Boundary case, DEPTH = 1: degenerates to a single-entry buffer per input. Maximum sustained rate is one result every 2 cycles.

Test Plan:
- Reset sequence: assert reset mid-stream with 2 entries buffered in each FIFO and Y_enable high -> immediately A_ready = B_ready = 0, Y_enable = 0, counts 0; one cycle after release A_ready = B_ready = 1; no stale result ever appears on Y.
- Streaming XOR: op = 0, WIDTH = 8, push A = 0x3C,0xFF,0x00 and B = 0x0F,0xAA,0x55 back-to-back, Y_ready = 1 -> Y = 0x33,0x55,0x55 on consecutive cycles, first valid 2 cycles after the first accept.
- Backpressure: Y_ready = 0, push 3 pairs with DEPTH = 2 -> first result held stable on Y; both FIFOs reach count 2; ready drops. Raise Y_ready -> all 3 results drain in order with no loss or duplication.
- Imbalance: push 2 A values only, no B -> A_count = 2, A_ready = 0, Y_enable stays 0. Push one B -> exactly one result emitted; A_count = 1.
- op select: one pair each for A = 0xF0, B = 0xCC with op = 1, 2, 3 -> Y = 0xC0, 0xFC, 0xC3. Toggle op while Y_enable & !Y_ready -> Y_data unchanged.
- Wrap-around: with DEPTH = 4, stream 20 random pairs with random Y_ready and random enables -> output sequence matches a reference model. Also cover simultaneous push and pop while at count 1.
